// File: rtl/accumulator_drain_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// accumulator_drain_ctrl_pkg
//   Shared definitions for the accumulator drain controller:
//   - state encoding of the sequencing FSM
//   - default lane count, result width and feed-to-accumulator latency
//   - helper that computes the final ACCUM counter value
// ---------------------------------------------------------------------------
package accumulator_drain_ctrl_pkg;

   // State encodings
   localparam logic [1:0] IDLE_ENC  = 2'd0;
   localparam logic [1:0] CLR_ENC   = 2'd1;
   localparam logic [1:0] ACCUM_ENC = 2'd2;
   localparam logic [1:0] DRAIN_ENC = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = IDLE_ENC,
      ST_CLR   = CLR_ENC,
      ST_ACCUM = ACCUM_ENC,
      ST_DRAIN = DRAIN_ENC
   } state_e;

   // Defaults for the array top
   localparam int DEF_LANES = 4;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_LAT   = 1;

   // k_len is 8 bits; k_len + LAT needs one more bit
   localparam int KLEN_W = 8;
   localparam int CNT_W  = 9;

   // Counter value seen on the last ACCUM cycle: k_len + LAT - 1
   function automatic logic [CNT_W-1:0] accum_last_cnt(input logic [KLEN_W-1:0] k_len,
                                                       input int                lat);
      return {1'b0, k_len} + CNT_W'(lat - 1);
   endfunction

endpackage

// File: rtl/accumulator_drain_ctrl_lane_snapshot_buffer.sv
// ---------------------------------------------------------------------------
// lane_snapshot_buffer
//   Holds one snapshot of every accumulator lane. All lanes load together
//   when load_i is high; a single lane is selected for output by sel_i.
//
//   clk_i     system clock
//   clear_ni  asynchronous active-low clear of all lanes
//   load_i    parallel load of every lane from data_i
//   data_i    packed lane values, lane i at [i*WIDTH +: WIDTH]
//   sel_i     lane index to present
//   data_o    snapshot value of lane sel_i
// ---------------------------------------------------------------------------
module lane_snapshot_buffer
   import accumulator_drain_ctrl_pkg::*;
#(
   parameter int LANES = DEF_LANES,
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEL_W = $clog2(DEF_LANES)
) (
   input  logic                   clk_i,
   input  logic                   clear_ni,
   input  logic                   load_i,
   input  logic [LANES*WIDTH-1:0] data_i,
   input  logic [SEL_W-1:0]       sel_i,
   output logic [WIDTH-1:0]       data_o
);

   logic [LANES*WIDTH-1:0] snap_flat;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic [WIDTH-1:0] lane_q;

         always_ff @(posedge clk_i or negedge clear_ni) begin
            if (!clear_ni) begin
               lane_q <= '0;
            end else if (load_i) begin
               lane_q <= data_i[gi*WIDTH +: WIDTH];
            end
         end

         assign snap_flat[gi*WIDTH +: WIDTH] = lane_q;
      end
   endgenerate

   // Explicit compare loop keeps the mux well defined for non-power-of-2 LANES
   always_comb begin
      data_o = '0;
      for (int i = 0; i < LANES; i++) begin
         if (sel_i == SEL_W'(i)) begin
            data_o = snap_flat[i*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/accumulator_drain_ctrl.sv
// ---------------------------------------------------------------------------
// accumulator_drain_ctrl
//   Sequences one pass of the PE-column accumulators: clear them, gate the
//   operand feed for k_len cycles, wait out the pipeline latency, snapshot
//   every lane in one cycle, then drain the snapshot lane by lane over a
//   valid/ready handshake.
//
//   clk_i        system clock
//   clear_ni     asynchronous active-low reset (aborts any pass)
//   start_i      one-cycle pass request, honoured only when idle
//   k_len_i      number of accumulate cycles, captured with start_i
//   acc_in_i     accumulator outputs, lane i at [i*WIDTH +: WIDTH]
//   acc_clear_o  one-cycle pulse clearing the accumulators
//   feed_en_o    upstream feeder must present valid operands
//   out_valid_o  snapshot lane presented on out_data_o
//   out_ready_i  consumer accepts the presented lane
//   out_data_o   snapshot value of lane out_lane_o
//   out_lane_o   index of the lane presented
//   busy_o       high whenever a pass is in progress
//   done_o       one-cycle pulse after the last lane is accepted
// ---------------------------------------------------------------------------
module accumulator_drain_ctrl
   import accumulator_drain_ctrl_pkg::*;
#(
   parameter int LANES = DEF_LANES,
   parameter int WIDTH = DEF_WIDTH,
   parameter int LAT   = DEF_LAT
) (
   input  logic                       clk_i,
   input  logic                       clear_ni,
   input  logic                       start_i,
   input  logic [KLEN_W-1:0]          k_len_i,
   input  logic [LANES*WIDTH-1:0]     acc_in_i,
   output logic                       acc_clear_o,
   output logic                       feed_en_o,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [WIDTH-1:0]           out_data_o,
   output logic [$clog2(LANES)-1:0]   out_lane_o,
   output logic                       busy_o,
   output logic                       done_o
);

   localparam int                LANE_W    = $clog2(LANES);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   state_e              state_q;
   logic [KLEN_W-1:0]   k_len_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   logic [CNT_W-1:0]    cnt_last;
   logic [LANE_W-1:0]   out_lane_q;
   logic [LANE_W-1:0]   out_lane_d;
   logic                acc_clear_q;
   logic                feed_en_q;
   logic                out_valid_q;
   logic                busy_q;
   logic                done_q;

   logic                accum_end;
   logic                feed_next;
   logic                last_lane;

   always_comb begin
      cnt_d      = cnt_q + 9'd1;
      cnt_last   = accum_last_cnt(k_len_q, LAT);
      accum_end  = (state_q == ST_ACCUM) && (cnt_q == cnt_last);
      // feed_en is registered, so it is decided one count ahead
      feed_next  = (cnt_d < {1'b0, k_len_q});
      last_lane  = (out_lane_q == LAST_LANE);
      out_lane_d = last_lane ? '0 : out_lane_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge clear_ni) begin
      if (!clear_ni) begin
         state_q     <= ST_IDLE;
         k_len_q     <= '0;
         cnt_q       <= '0;
         out_lane_q  <= '0;
         acc_clear_q <= 1'b0;
         feed_en_q   <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         acc_clear_q <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  k_len_q     <= k_len_i;
                  acc_clear_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= ST_CLR;
               end
            end
            ST_CLR: begin
               cnt_q     <= '0;
               feed_en_q <= (k_len_q != '0);
               state_q   <= ST_ACCUM;
            end
            ST_ACCUM: begin
               cnt_q <= cnt_d;
               if (accum_end) begin
                  feed_en_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  out_lane_q  <= '0;
                  state_q     <= ST_DRAIN;
               end else begin
                  feed_en_q <= feed_next;
               end
            end
            ST_DRAIN: begin
               if (out_ready_i) begin
                  if (last_lane) begin
                     out_valid_q <= 1'b0;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                     state_q     <= ST_IDLE;
                  end else begin
                     out_lane_q <= out_lane_d;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Snapshot is taken on the final ACCUM cycle, when acc_in reflects the
   // last fed operand.
   lane_snapshot_buffer #(
      .LANES (LANES),
      .WIDTH (WIDTH),
      .SEL_W (LANE_W)
   ) u_snapshot (
      .clk_i    (clk_i),
      .clear_ni (clear_ni),
      .load_i   (accum_end),
      .data_i   (acc_in_i),
      .sel_i    (out_lane_q),
      .data_o   (out_data_o)
   );

   assign acc_clear_o = acc_clear_q;
   assign feed_en_o   = feed_en_q;
   assign out_valid_o = out_valid_q;
   assign out_lane_o  = out_lane_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_accumulator_drain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_accumulator_drain_ctrl
//   Directed checks for accumulator_drain_ctrl (LANES=4, WIDTH=8, LAT=1).
//   Cycle n is the interval after the n-th rising edge of a sequence; outputs
//   are sampled 1 time unit after the edge and inputs are then driven for
//   that cycle.
// ---------------------------------------------------------------------------
module tb_accumulator_drain_ctrl;

   logic        clk = 1'b0;
   logic        clear_n;
   logic        start;
   logic [7:0]  k_len;
   logic [31:0] acc_in;
   logic        out_ready;
   logic        acc_clear;
   logic        feed_en;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_lane;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   accumulator_drain_ctrl #(
      .LANES (4),
      .WIDTH (8),
      .LAT   (1)
   ) dut (
      .clk_i       (clk),
      .clear_ni    (clear_n),
      .start_i     (start),
      .k_len_i     (k_len),
      .acc_in_i    (acc_in),
      .acc_clear_o (acc_clear),
      .feed_en_o   (feed_en),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_lane_o  (out_lane),
      .busy_o      (busy),
      .done_o      (done)
   );

   // One line per accepted lane (inputs are stable at the falling edge)
   always @(negedge clk) begin
      if (clear_n && out_valid && out_ready)
         $display("xfer lane %0d data %02h t=%0t", out_lane, out_data, $time);
   end

   typedef struct {
      logic       start;
      logic [7:0] k;
      logic       clr;
      logic       fe;
      logic       v;
      int         lane;
      int         data;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input int c, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
      end
   endtask

   task automatic chk_cycle(input string tag, input int c, input logic clr,
                            input logic fe, input logic v, input int lane,
                            input int data, input logic bsy, input logic dn);
      chk({tag, " acc_clear"}, c, 32'(acc_clear), 32'(clr));
      chk({tag, " feed_en"},   c, 32'(feed_en),   32'(fe));
      chk({tag, " out_valid"}, c, 32'(out_valid), 32'(v));
      chk({tag, " busy"},      c, 32'(busy),      32'(bsy));
      chk({tag, " done"},      c, 32'(done),      32'(dn));
      if (v) begin
         chk({tag, " out_lane"}, c, 32'(out_lane), lane);
         chk({tag, " out_data"}, c, 32'(out_data), data);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vec(input int i, input logic s, input logic [7:0] k,
                          input logic clr, input logic fe, input logic v,
                          input int lane, input int data, input logic bsy,
                          input logic dn);
      tbl[i].start = s;   tbl[i].k    = k;    tbl[i].clr  = clr;
      tbl[i].fe    = fe;  tbl[i].v    = v;    tbl[i].lane = lane;
      tbl[i].data  = data; tbl[i].busy = bsy; tbl[i].done = dn;
   endtask

   // Basic pass; with inject set, extra starts (k_len=9) land in ACCUM and DRAIN
   task automatic run_table(input string tag, input bit inject);
      for (int c = 0; c < 12; c++) begin
         chk_cycle(tag, c, tbl[c].clr, tbl[c].fe, tbl[c].v, tbl[c].lane,
                   tbl[c].data, tbl[c].busy, tbl[c].done);
         start = tbl[c].start;
         k_len = tbl[c].k;
         if (inject && (c == 3 || c == 7)) begin
            start = 1'b1;
            k_len = 8'd9;
         end
         tick();
      end
      start = 1'b0;
   endtask

   // k_len=1 pass on acc_in=0x0d0c0b0a; returns without advancing at stop_at
   task automatic pass_k1(input string tag, input int stop_at);
      for (int c = 0; c < 10; c++) begin
         chk_cycle(tag, c, c == 1, c == 2, c >= 4 && c <= 7, c - 4,
                   32'h0a + c - 4, c >= 1 && c <= 7, c == 8);
         if (c == stop_at) return;
         start = (c == 0);
         k_len = 8'd1;
         tick();
      end
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      set_vec(0,  1'b1, 8'd3, 0, 0, 0, 0, 8'h00, 0, 0);
      set_vec(1,  1'b0, 8'd0, 1, 0, 0, 0, 8'h00, 1, 0);
      set_vec(2,  1'b0, 8'd0, 0, 1, 0, 0, 8'h00, 1, 0);
      set_vec(3,  1'b0, 8'd0, 0, 1, 0, 0, 8'h00, 1, 0);
      set_vec(4,  1'b0, 8'd0, 0, 1, 0, 0, 8'h00, 1, 0);
      set_vec(5,  1'b0, 8'd0, 0, 0, 0, 0, 8'h00, 1, 0);
      set_vec(6,  1'b0, 8'd0, 0, 0, 1, 0, 8'h10, 1, 0);
      set_vec(7,  1'b0, 8'd0, 0, 0, 1, 1, 8'h20, 1, 0);
      set_vec(8,  1'b0, 8'd0, 0, 0, 1, 2, 8'h30, 1, 0);
      set_vec(9,  1'b0, 8'd0, 0, 0, 1, 3, 8'h40, 1, 0);
      set_vec(10, 1'b0, 8'd0, 0, 0, 0, 0, 8'h00, 0, 1);
      set_vec(11, 1'b0, 8'd0, 0, 0, 0, 0, 8'h00, 0, 0);

      clear_n   = 1'b1;
      start     = 1'b0;
      k_len     = 8'd0;
      acc_in    = 32'h4030_2010;
      out_ready = 1'b1;
      #1 clear_n = 1'b0;
      #2;
      // Reset state
      chk_cycle("reset", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("reset out_lane", 0, 32'(out_lane), 32'd0);
      chk("reset out_data", 0, 32'(out_data), 32'd0);
      #9 clear_n = 1'b1;
      tick();

      // Basic pass
      run_table("basic", 1'b0);

      // Backpressure: out_ready low in cycles 6-8
      for (int c = 0; c < 15; c++) begin
         int ln;
         ln = (c <= 9) ? 0 : c - 9;
         chk_cycle("bp", c, c == 1, c >= 2 && c <= 4, c >= 6 && c <= 12, ln,
                   16 * (ln + 1), c >= 1 && c <= 12, c == 13);
         start     = (c == 0);
         k_len     = 8'd3;
         out_ready = !(c >= 6 && c <= 8);
         tick();
      end
      start     = 1'b0;
      out_ready = 1'b1;

      // k_len=0: bench accumulators read 0x55 until cleared
      acc_in = 32'h5555_5555;
      for (int c = 0; c < 9; c++) begin
         chk_cycle("k0", c, c == 1, 1'b0, c >= 3 && c <= 6, c - 3, 0,
                   c >= 1 && c <= 6, c == 7);
         if (acc_clear) acc_in = 32'h0;
         start = (c == 0);
         k_len = 8'd0;
         tick();
      end
      start = 1'b0;

      // Starts during ACCUM and DRAIN are ignored
      acc_in = 32'h4030_2010;
      run_table("ign", 1'b1);

      // Snapshot isolation, then a start coinciding with done
      acc_in = 32'h0403_0201;
      for (int c = 0; c < 19; c++) begin
         int ln;
         int dt;
         if (c == 5) acc_in = 32'hFFFF_FFFF;
         ln = (c <= 8) ? c - 5 : c - 13;
         dt = (c <= 8) ? ln + 1 : 32'hFF;
         chk_cycle("iso", c, c == 1 || c == 10, c == 2 || c == 3 || c == 11,
                   (c >= 5 && c <= 8) || (c >= 13 && c <= 16), ln, dt,
                   (c >= 1 && c <= 8) || (c >= 10 && c <= 16),
                   c == 9 || c == 17);
         start = (c == 0 || c == 9);
         k_len = (c == 9) ? 8'd1 : 8'd2;
         tick();
      end
      start = 1'b0;

      // Asynchronous reset while lane 2 is presented
      acc_in = 32'h0d0c_0b0a;
      pass_k1("prerst", 6);
      #2 clear_n = 1'b0;
      #1;
      chk("rst out_valid", 6, 32'(out_valid), 32'd0);
      chk("rst busy",      6, 32'(busy),      32'd0);
      chk("rst out_lane",  6, 32'(out_lane),  32'd0);
      chk("rst out_data",  6, 32'(out_data),  32'd0);
      #2 clear_n = 1'b1;
      tick();
      pass_k1("postrst", 99);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/accumulator_drain_ctrl.md
Name: accumulator_drain_ctrl

Overview:
- Sequencing and result-collection stage directly downstream of the PE-column 8-bit accumulators.
- On a start pulse it clears the accumulators, then gates the upstream operand feed for k_len MAC cycles.
- After the pipeline latency it snapshots all lane results in one cycle.
- It then drains the snapshot one lane at a time over a valid/ready handshake to the output/write-back logic.

Parameters:
- LANES, 4, number of accumulator lanes collected per pass.
- WIDTH, 8, accumulator result width in bits.
- LAT, 1, cycles from the last feed_en cycle until that operand is reflected on acc_in; legal range 1..3.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- clear  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a pass; sampled only in IDLE.
- k_len  input  8  number of accumulate cycles; captured together with start.
- acc_in  input  LANES*WIDTH  accumulator outputs; lane i occupies bits [i*WIDTH +: WIDTH].
- acc_clear  output  1  one-cycle active-high pulse to the accumulator clear inputs.
- feed_en  output  1  high while the upstream feeder must present valid operands.
- out_valid  output  1  snapshot lane presented on out_data.
- out_ready  input  1  consumer accepts the current lane.
- out_data  output  WIDTH  snapshot value of lane out_lane.
- out_lane  output  clog2(LANES)  index of the lane currently presented.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last lane is accepted.

Behaviour:
- Reset (clear=0, async):
  - State goes to IDLE immediately.
  - acc_clear, feed_en, out_valid, busy and done are all 0.
  - out_data, out_lane, the snapshot registers, the counter and the captured k_len are all 0.
  - Reset asserted mid-pass aborts the pass and loses the snapshot.
- States: IDLE, CLR, ACCUM, DRAIN.
- IDLE:
  - start=1 captures k_len and moves to CLR.
  - start in any other state is ignored; no queuing.
- CLR:
  - Lasts exactly one cycle with acc_clear=1.
  - Cycle counter loads 0.
  - Moves to ACCUM.
- ACCUM:
  - Lasts k_len+LAT cycles; the counter counts 0..k_len+LAT-1 and is 9 bits wide.
  - feed_en=1 while counter<k_len.
  - On the final ACCUM cycle all lanes of acc_in are registered into the snapshot; lane index resets to 0; next state is DRAIN.
  - k_len=0: feed_en never asserts, ACCUM lasts LAT cycles, and the snapshot holds the cleared accumulator values (0).
- DRAIN:
  - out_valid=1, out_data=snapshot[out_lane].
  - Data and lane stay stable until out_valid&&out_ready.
  - Each handshake increments out_lane. A handshake on lane LANES-1 moves to IDLE.
  - done=1 in the first IDLE cycle; out_valid drops in that same cycle.
  - With out_ready held high, one lane drains per cycle.
- Arithmetic: no arithmetic on data. Values pass through unchanged, so any accumulator wrap modulo 2^WIDTH is preserved.
- A start coinciding with done is accepted, because the block is in IDLE.
- acc_in changes outside the snapshot cycle have no effect.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=0, CLR=1, ACCUM=2, DRAIN=3);
  - default LANES/WIDTH/LAT constants used by the array top.
- One natural sub-module: lane_snapshot_buffer.
  - LANES×WIDTH registers with a parallel load enable and an async active-low clear.
  - Indexed read mux for out_data.
- The FSM and counter stay in the top module.

Test Plan:
- Basic pass (LAT=1):
  - Stimulus: bench holds acc_in lanes = 0x10,0x20,0x30,0x40 (lane0..3); start=1 with k_len=3 at cycle 0; out_ready=1.
  - acc_clear=1 at cycle 1; feed_en=1 at cycles 2-4; ACCUM spans cycles 2-5.
  - out_valid at cycles 6-9 with lane/data (0,0x10),(1,0x20),(2,0x30),(3,0x40).
  - done=1 and busy=0 at cycle 10.
- Backpressure:
  - Stimulus: same as the basic pass, but out_ready=0 during cycles 6-8.
  - out_data holds 0x10 with lane 0 through cycle 8; lane 1 appears at cycle 10; done at cycle 13.
- k_len=0:
  - Stimulus: start with k_len=0.
  - feed_en never asserts; snapshot is taken at cycle 2 from the bench's post-clear value 0x00.
  - Four drained words of 0x00.
- Ignored start:
  - Stimulus: pulse start during ACCUM and again during DRAIN.
  - No change to the counter, the lane sequence or the done timing.
- Async reset mid-DRAIN:
  - Stimulus: drive clear=0 between clock edges while presenting lane 2.
  - out_valid, busy and out_lane go to 0 immediately.
  - After release, a new start runs a full pass that begins again at lane 0.
- Snapshot isolation:
  - Stimulus: change acc_in to 0xFF on all lanes one cycle after the snapshot cycle.
  - Drained values remain the captured ones.
